if_id_buffer: RTL and testbench

Two-entry instruction buffer between the fetch stage and the decode stage: the consuming end of the fetch interface.
- Accepts {instruction, PC+4} pairs from fetch using a valid/ready handshake.
- Presents them to decode in order.
- Discards buffered entries on a branch/jump flush.
- Decouples fetch from decode stalls without dropping or duplicating instructions.

---
 rtl/if_id_buffer_if.sv | 31 +++
 rtl/if_id_buffer.sv | 130 +++++++++++++
 tb/tb_if_id_buffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer_if
// Description : Fetch-side and decode-side handshake bundle for the IF/ID
//               instruction buffer. The "slave" modport is the buffer's view;
//               the "master" modport is the surrounding pipeline's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_buffer_if #(
   parameter int DATA_W = 32
);
   logic              IF_Valid;
   logic              IF_Ready;
   logic [DATA_W-1:0] IF_Instruction;
   logic [DATA_W-1:0] IF_PCPlus4;
   logic              ID_Valid;
   logic              ID_Ready;
   logic [DATA_W-1:0] ID_Instruction;
   logic [DATA_W-1:0] ID_PCPlus4;

   modport slave (
      input  IF_Valid, IF_Instruction, IF_PCPlus4, ID_Ready,
      output IF_Ready, ID_Valid, ID_Instruction, ID_PCPlus4
   );

   modport master (
      output IF_Valid, IF_Instruction, IF_PCPlus4, ID_Ready,
      input  IF_Ready, ID_Valid, ID_Instruction, ID_PCPlus4
   );
endinterface
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Two-entry in-order instruction buffer between fetch and
//               decode. Accepts {instruction, PC+4} pairs over a valid/ready
//               handshake, presents the head entry to decode, and discards
//               everything on Flush. Optional feature macro
//               IFID_BUBBLE_COUNT_EN adds a saturating BubbleCount output
//               counting edges where decode was ready but the buffer empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  wire logic     Clk,
   input  wire logic     Reset,
   input  wire logic     Flush,
   if_id_buffer_if.slave bus,
   output logic [1:0]    Occupancy
`ifdef IFID_BUBBLE_COUNT_EN
   ,
   output logic [15:0]   BubbleCount
`endif
);

   localparam logic [DATA_W-1:0] c_NOP = '0;

   // State encoding equals the entry count so Occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [DATA_W-1:0] r_instr [DEPTH];
   logic [DATA_W-1:0] r_pc    [DEPTH];

   logic w_id_valid;
   logic w_if_ready;
   logic w_push;
   logic w_pop;

   // Flush blocks both sides so a same-cycle push or pop cannot survive it.
   assign w_id_valid = (r_state != ST_EMPTY);
   assign w_if_ready = (r_state != ST_FULL) && !Flush && !Reset;
   assign w_push     = bus.IF_Valid && w_if_ready;
   assign w_pop      = w_id_valid && bus.ID_Ready && !Flush;

   assign bus.IF_Ready       = w_if_ready;
   assign bus.ID_Valid       = w_id_valid;
   assign bus.ID_Instruction = w_id_valid ? r_instr[r_rd_ptr] : c_NOP;
   assign bus.ID_PCPlus4     = w_id_valid ? r_pc[r_rd_ptr]    : c_NOP;
   assign Occupancy          = r_state;

   // State register: entry count tracked as EMPTY/ONE/FULL.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: push/pop transitions, Flush overriding everything.
   always_comb begin
      w_state_next = r_state;
      if (Flush) begin
         w_state_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_push) w_state_next = ST_ONE;
            ST_ONE: begin
               if (w_push && !w_pop)      w_state_next = ST_FULL;
               else if (w_pop && !w_push) w_state_next = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) w_state_next = ST_ONE;
            default:  w_state_next = ST_EMPTY;
         endcase
      end
   end

   // Ring pointers: toggle on push/pop, both return to slot 0 on Flush.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else if (Flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      end
   end

   // Entry storage: written at the write pointer on an accepted push.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= '0;
            r_pc[i]    <= '0;
         end
      end else if (w_push) begin
         r_instr[r_wr_ptr] <= bus.IF_Instruction;
         r_pc[r_wr_ptr]    <= bus.IF_PCPlus4;
      end
   end

`ifdef IFID_BUBBLE_COUNT_EN
   logic [15:0] r_bubble_cnt;

   // Bubble counter: decode ready with nothing to give it; saturates, Flush does not clear.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_bubble_cnt <= 16'd0;
      end else if (bus.ID_Ready && !w_id_valid && !Flush && (r_bubble_cnt != 16'hFFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   assign BubbleCount = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Self-checking bench for if_id_buffer. A queue-based model of
//               the buffer is compared against the DUT every falling edge;
//               directed vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Flush;
   logic [1:0]  Occupancy;
`ifdef IFID_BUBBLE_COUNT_EN
   logic [15:0] BubbleCount;
`endif

   if_id_buffer_if #(.DATA_W(32)) bus ();

   if_id_buffer #(
      .DEPTH (2),
      .DATA_W(32)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Flush      (Flush),
      .bus        (bus),
      .Occupancy  (Occupancy)
`ifdef IFID_BUBBLE_COUNT_EN
      ,
      .BubbleCount(BubbleCount)
`endif
   );

   always #5 Clk = ~Clk;

   int n_total = 0;
   int n_pass  = 0;

   // Model: FIFO contents, decode-consumed history, bubble count.
   logic [31:0] m_ins [$];
   logic [31:0] m_pc  [$];
   logic [31:0] popped [$];
   int          m_bub = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ins.delete();
      m_pc.delete();
      m_bub = 0;
   endtask

   // Apply the buffer rules for one rising edge using the current inputs.
   task automatic model_edge();
      bit do_push;
      bit do_pop;
      do_push = bus.IF_Valid && (m_ins.size() < 2) && !Flush;
      do_pop  = (m_ins.size() != 0) && bus.ID_Ready && !Flush;
      if (bus.ID_Ready && (m_ins.size() == 0) && !Flush && (m_bub < 65535)) m_bub++;
      if (Flush) begin
         m_ins.delete();
         m_pc.delete();
      end else begin
         if (do_pop) begin
            popped.push_back(m_ins[0]);
            void'(m_ins.pop_front());
            void'(m_pc.pop_front());
         end
         if (do_push) begin
            m_ins.push_back(bus.IF_Instruction);
            m_pc.push_back(bus.IF_PCPlus4);
         end
      end
   endtask

   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      bus.IF_Valid       = v;
      bus.IF_Instruction = ins;
      bus.IF_PCPlus4     = pc;
      bus.ID_Ready       = rdy;
      Flush              = fl;
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   // Compare DUT against the model every falling edge.
   always @(negedge Clk) begin
      check("cmp_occupancy", 64'(Occupancy), 64'(m_ins.size()));
      check("cmp_id_valid", 64'(bus.ID_Valid), 64'(m_ins.size() != 0));
      check("cmp_id_instr", 64'(bus.ID_Instruction), 64'((m_ins.size() != 0) ? m_ins[0] : 32'h0));
      check("cmp_id_pc", 64'(bus.ID_PCPlus4), 64'((m_pc.size() != 0) ? m_pc[0] : 32'h0));
      check("cmp_if_ready", 64'(bus.IF_Ready), 64'((m_ins.size() < 2) && !Flush && !Reset));
`ifdef IFID_BUBBLE_COUNT_EN
      check("cmp_bubble", 64'(BubbleCount), 64'(m_bub));
`endif
   end

   initial begin
      Reset              = 1'b1;
      Flush              = 1'b0;
      bus.IF_Valid       = 1'b0;
      bus.IF_Instruction = 32'h0;
      bus.IF_PCPlus4     = 32'h0;
      bus.ID_Ready       = 1'b0;
      model_reset();

      @(posedge Clk); #1;
      check("rst_occupancy", 64'(Occupancy), 64'd0);
      check("rst_id_valid", 64'(bus.ID_Valid), 64'd0);
      check("rst_id_instr", 64'(bus.ID_Instruction), 64'd0);
      check("rst_if_ready", 64'(bus.IF_Ready), 64'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // Push-pop stream with decode always ready.
      step(1'b1, 32'h8C080004, 32'h4, 1'b1, 1'b0);
      check("stream1_instr", 64'(bus.ID_Instruction), 64'h8C080004);
      check("stream1_pc", 64'(bus.ID_PCPlus4), 64'h4);
      check("stream1_occ", 64'(Occupancy), 64'd1);
      step(1'b1, 32'h21290001, 32'h8, 1'b1, 1'b0);
      check("stream2_instr", 64'(bus.ID_Instruction), 64'h21290001);
      check("stream2_pc", 64'(bus.ID_PCPlus4), 64'h8);
      check("stream2_occ", 64'(Occupancy), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("stream3_valid", 64'(bus.ID_Valid), 64'd0);
      check("stream3_instr", 64'(bus.ID_Instruction), 64'd0);

      // Backpressure: fill, hold third entry until accepted, then drain.
      popped.delete();
      step(1'b1, 32'hAAAA0001, 32'h10, 1'b0, 1'b0);
      step(1'b1, 32'hAAAA0002, 32'h14, 1'b0, 1'b0);
      check("bp_full_occ", 64'(Occupancy), 64'd2);
      check("bp_full_ready", 64'(bus.IF_Ready), 64'd0);
      step(1'b1, 32'hAAAA0003, 32'h18, 1'b0, 1'b0);
      check("bp_hold_occ", 64'(Occupancy), 64'd2);
      check("bp_hold_head", 64'(bus.ID_Instruction), 64'hAAAA0001);
      step(1'b1, 32'hAAAA0003, 32'h18, 1'b1, 1'b0);
      check("bp_pop1_head", 64'(bus.ID_Instruction), 64'hAAAA0002);
      check("bp_pop1_occ", 64'(Occupancy), 64'd1);
      step(1'b1, 32'hAAAA0003, 32'h18, 1'b1, 1'b0);
      check("bp_pop2_head", 64'(bus.ID_Instruction), 64'hAAAA0003);
      check("bp_pop2_pc", 64'(bus.ID_PCPlus4), 64'h18);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_drained_occ", 64'(Occupancy), 64'd0);
      check("bp_popped_cnt", 64'(popped.size()), 64'd3);
      if (popped.size() == 3) begin
         check("bp_popped0", 64'(popped[0]), 64'hAAAA0001);
         check("bp_popped1", 64'(popped[1]), 64'hAAAA0002);
         check("bp_popped2", 64'(popped[2]), 64'hAAAA0003);
      end

      // Simultaneous push and pop at one entry.
      step(1'b1, 32'h11111111, 32'h20, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 32'h24, 1'b1, 1'b0);
      check("pp_occ", 64'(Occupancy), 64'd1);
      check("pp_head", 64'(bus.ID_Instruction), 64'h22222222);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush while full with a concurrent push offered.
      step(1'b1, 32'h44440001, 32'h30, 1'b0, 1'b0);
      step(1'b1, 32'h44440002, 32'h34, 1'b0, 1'b0);
      step(1'b1, 32'h33333333, 32'h38, 1'b0, 1'b1);
      check("fl_valid", 64'(bus.ID_Valid), 64'd0);
      check("fl_instr", 64'(bus.ID_Instruction), 64'd0);
      check("fl_occ", 64'(Occupancy), 64'd0);
      step(1'b1, 32'h55555555, 32'h3C, 1'b0, 1'b0);
      check("fl_next_head", 64'(bus.ID_Instruction), 64'h55555555);
      check("fl_next_occ", 64'(Occupancy), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("fl_next_drained", 64'(Occupancy), 64'd0);

      // Asynchronous reset mid-cycle while full.
      step(1'b1, 32'h66660001, 32'h40, 1'b0, 1'b0);
      step(1'b1, 32'h66660002, 32'h44, 1'b0, 1'b0);
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      check("arst_occ", 64'(Occupancy), 64'd0);
      check("arst_valid", 64'(bus.ID_Valid), 64'd0);
      check("arst_instr", 64'(bus.ID_Instruction), 64'd0);
      check("arst_pc", 64'(bus.ID_PCPlus4), 64'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      step(1'b1, 32'h77777777, 32'h50, 1'b0, 1'b0);
      check("arst_push_head", 64'(bus.ID_Instruction), 64'h77777777);
      check("arst_push_occ", 64'(Occupancy), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Empty: pop request and flush have no visible effect; next push normal.
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("empty_pop_occ", 64'(Occupancy), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check("empty_flush_occ", 64'(Occupancy), 64'd0);
      step(1'b1, 32'h88888888, 32'h60, 1'b0, 1'b0);
      check("empty_push_head", 64'(bus.ID_Instruction), 64'h88888888);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IFID_BUBBLE_COUNT_EN
      // Bubble counting: five empty-ready edges, then a flush edge (not counted).
      Reset = 1'b1;
      model_reset();
      @(posedge Clk); #1;
      Reset = 1'b0;
      repeat (5) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("bub_five", 64'(BubbleCount), 64'd5);
      repeat (65535) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bub_sat", 64'(BubbleCount), 64'hFFFF);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bub_sat_hold", 64'(BubbleCount), 64'hFFFF);
`endif

      bus.ID_Ready = 1'b0;
      @(negedge Clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
